// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
package spi_pkg;
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } spi_rx_state_t;

    localparam int SPI_LEAD_EDGES = 1;
    localparam int SPI_DATA_W     = 12;
endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO with power-of-2 depth; pointers carry one extra wrap bit.
module spi_rx_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/spi_rx.sv
// SPI receiver: oversampled LSB-first deserialiser with frame-length check.
// Define SPI_RX_FIFO_EN to replace the single holding register with a FIFO.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CNT_W    = $clog2(DATA_W + 3);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]    GOOD_CNT    = CNT_W'(DATA_W + SPI_LEAD_EDGES);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2");
    end

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d, cs_hist_q, cs_hist_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic                   sclk_s, cs_s, mosi_s, edge_en;
    logic                   sclk_fall, cs_fall, cs_rise;
    spi_rx_state_t          state_q, state_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic                   frame_err_q, frame_err_d, push;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edges are masked until the chains and history flops hold post-reset samples,
    // so a cs already low at reset release never looks like a new frame.
    assign edge_en   = (settle_q == SETTLE_DONE);
    assign sclk_fall = edge_en && sclk_hist_q && !sclk_s;
    assign cs_fall   = edge_en && cs_hist_q && !cs_s;
    assign cs_rise   = edge_en && !cs_hist_q && cs_s;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_hist_d = sclk_s;
        cs_hist_d   = cs_s;
        settle_d    = edge_en ? settle_q : settle_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        edge_cnt_d  = edge_cnt_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    shreg_d    = '0;
                    edge_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
                    if (edge_cnt_q != CNT_MAX) edge_cnt_d = edge_cnt_q + 1'b1;
                end
                if (cs_rise) state_d = CHECK;
            end
            CHECK: begin
                if (edge_cnt_q == GOOD_CNT) push = 1'b1;
                else                        frame_err_d = 1'b1;
                if (cs_fall) begin
                    state_d    = SHIFT;
                    shreg_d    = '0;
                    edge_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
            settle_q    <= '0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            edge_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            settle_q    <= settle_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            edge_cnt_q  <= edge_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

`ifdef SPI_RX_FIFO_EN
    logic              fifo_empty, fifo_full, pop, overrun_q, overrun_d;
    logic [DATA_W-1:0] head_data;

    assign pop = !fifo_empty && dout_ready;

    spi_rx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg_q),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb overrun_d = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    // Stale RAM contents are hidden so dout reads zero whenever nothing is held.
    assign dout       = fifo_empty ? '0 : head_data;
    assign dout_valid = !fifo_empty;
    assign overrun    = overrun_q;
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d, overrun_q, overrun_d, pop;

    assign pop = dout_valid_q && dout_ready;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
        if (pop) dout_valid_d = 1'b0;
        if (push) begin
            if (!dout_valid_q || pop) begin
                dout_d       = shreg_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
`endif
endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: vector table plus hand-written corner sequences.
module tb_spi_rx;
    localparam int DW   = 12;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst, sclk, cs, mosi, dout_ready;
    logic [DW-1:0] dout;
    logic          dout_valid, frame_err, overrun;

    int            errors = 0, checks = 0;
    int            n_deliv = 0, n_ferr = 0, n_ovr = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] word;
        int            nfalls;
        bit            good;
    } vec_t;

    vec_t vecs[8];

    spi_rx #(.DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs change just after rising edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (dout_valid && dout_ready) begin
                n_deliv++;
                $display("word %h accepted at %0t", dout, $time);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected no word", dout);
                end else begin
                    check("dout_word", 32'(dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        sclk = 1'b1;
        mosi = b;
        repeat (HALF) tick();
        sclk = 1'b0;
        repeat (HALF) tick();
    endtask

    // nfalls counts every falling sclk edge, the lead-in edge included.
    task automatic send_frame(input logic [DW-1:0] word, input int nfalls);
        cs = 1'b0;
        repeat (HALF) tick();
        for (int i = 0; i < nfalls; i++) begin
            if (i >= 1 && i - 1 < DW) drive_bit(word[i-1]);
            else                      drive_bit(1'b0);
        end
        cs = 1'b1;
    endtask

    initial begin
        int            d0, f0, o0, first, vcnt;
        logic [DW-1:0] rw;

        vecs[0] = '{12'h001, 13, 1'b1};
        vecs[1] = '{12'hFFF, 13, 1'b1};
        vecs[2] = '{12'h5A3,  7, 1'b0};
        vecs[3] = '{12'h123, 14, 1'b0};
        vecs[4] = '{12'h456, 12, 1'b0};
        vecs[5] = '{12'h3C3, 13, 1'b1};
        vecs[6] = '{12'h800, 29, 1'b0};
        vecs[7] = '{12'h7E1, 13, 1'b1};

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; dout_ready = 1'b1;
        repeat (3) tick();
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Latency and single valid cycle for a good frame with ready tied high.
        f0 = n_ferr;
        exp_q.push_back(12'hA5C);
        send_frame(12'hA5C, 13);
        first = -1;
        vcnt  = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (dout_valid) begin
                vcnt++;
                if (first < 0) first = j;
            end
        end
        check("latency", 32'(first + 1), 4);
        check("valid_cycles", 32'(vcnt), 1);
        check("a5c_frame_err", 32'(n_ferr - f0), 0);

        for (int v = 0; v < 8; v++) begin
            d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
            if (vecs[v].good) exp_q.push_back(vecs[v].word);
            send_frame(vecs[v].word, vecs[v].nfalls);
            repeat (16) tick();
            check($sformatf("vec%0d_deliv", v), 32'(n_deliv - d0), vecs[v].good ? 1 : 0);
            check($sformatf("vec%0d_ferr", v), 32'(n_ferr - f0), vecs[v].good ? 0 : 1);
            check($sformatf("vec%0d_ovr", v), 32'(n_ovr - o0), 0);
        end

`ifndef SPI_RX_FIFO_EN
        // Second word arrives while the first is still held.
        dout_ready = 1'b0;
        d0 = n_deliv; o0 = n_ovr;
        exp_q.push_back(12'h001);
        send_frame(12'h001, 13);
        repeat (10) tick();
        send_frame(12'hFFF, 13);
        repeat (10) tick();
        check("ovr_dout_held", 32'(dout), 32'h001);
        check("ovr_valid", 32'(dout_valid), 1);
        check("ovr_pulses", 32'(n_ovr - o0), 1);
        check("ovr_no_deliv", 32'(n_deliv - d0), 0);
        dout_ready = 1'b1;
        repeat (10) tick();
        check("ovr_drain_deliv", 32'(n_deliv - d0), 1);
        check("ovr_drain_valid", 32'(dout_valid), 0);
`else
        dout_ready = 1'b0;
        d0 = n_deliv; o0 = n_ovr;
        for (int w = 1; w <= 5; w++) begin
            if (w <= 4) exp_q.push_back(12'h100 + 12'(w));
            send_frame(12'h100 + 12'(w), 13);
            repeat (10) tick();
        end
        check("fifo_ovr_pulses", 32'(n_ovr - o0), 1);
        check("fifo_head", 32'(dout), 32'h101);
        dout_ready = 1'b1;
        repeat (10) tick();
        check("fifo_drain_deliv", 32'(n_deliv - d0), 4);
        check("fifo_drain_valid", 32'(dout_valid), 0);
`endif

        // Ready rises exactly in the CHECK cycle that pushes the second word.
        dout_ready = 1'b0;
        d0 = n_deliv; o0 = n_ovr;
        exp_q.push_back(12'h001);
        send_frame(12'h001, 13);
        repeat (10) tick();
        exp_q.push_back(12'hFFF);
        send_frame(12'hFFF, 13);
        repeat (3) tick();
        dout_ready = 1'b1;
        tick();
        check("swap_dout", 32'(dout), 32'hFFF);
        check("swap_valid", 32'(dout_valid), 1);
        repeat (10) tick();
        check("swap_ovr", 32'(n_ovr - o0), 0);
        check("swap_deliv", 32'(n_deliv - d0), 2);

        // Reset in the middle of a frame; the tail of that frame must be ignored.
        rw = 12'hABC;
        cs = 1'b0;
        repeat (HALF) tick();
        drive_bit(1'b0);
        for (int b = 0; b < 5; b++) drive_bit(rw[b]);
        rst = 1'b1;
        repeat (2) tick();
        check("midrst_dout", 32'(dout), 0);
        check("midrst_valid", 32'(dout_valid), 0);
        check("midrst_ferr", 32'(frame_err), 0);
        rst = 1'b0;
        d0 = n_deliv; f0 = n_ferr;
        for (int b = 5; b < DW; b++) drive_bit(rw[b]);
        cs = 1'b1;
        repeat (16) tick();
        check("midrst_tail_ferr", 32'(n_ferr - f0), 0);
        check("midrst_tail_deliv", 32'(n_deliv - d0), 0);
        exp_q.push_back(12'h3C3);
        send_frame(12'h3C3, 13);
        repeat (16) tick();
        check("post_rst_deliv", 32'(n_deliv - d0), 1);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
